// File: rtl/recibir_datos.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre and
// presents the received byte with a one-cycle listo strobe.
module recibir_datos #(
    parameter int CLKS_PER_BIT = 5208,  // must be >= 4
    parameter int SYNC_STAGES  = 2      // 2..3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] datos,
    output logic       listo,
    output logic       error_trama,
    output logic       ocupado
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [7:0]           shreg, shreg_n;
    logic [7:0]           datos_n;
    logic                 listo_n, error_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rxs;

    // Reset the chain to the idle level so a reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], rx};
    end

    assign rxs = sync[SYNC_STAGES-1];

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        datos_n   = datos;
        listo_n   = 1'b0;
        error_n   = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF_CNT) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    // A start bit that is gone by its centre was a glitch.
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_n            = '0;
                    shreg_n[bit_idx] = rxs;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (rxs) begin
                        datos_n = shreg;
                        listo_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        error_n = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                // A line stuck low must return high before a new frame can start.
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            datos       <= 8'h00;
            listo       <= 1'b0;
            error_trama <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            datos       <= datos_n;
            listo       <= listo_n;
            error_trama <= error_n;
        end
    end

    assign ocupado = (state != IDLE);

endmodule

// File: tb/tb_recibir_datos.sv
// Self-checking bench for recibir_datos: directed scenarios plus random
// frames, scored against a queue of bytes the serial model has sent.
module tb_recibir_datos;

    localparam int CPB = 16;
    localparam int SS  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] datos;
    logic       listo;
    logic       error_trama;
    logic       ocupado;

    recibir_datos #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .datos       (datos),
        .listo       (listo),
        .error_trama (error_trama),
        .ocupado     (ocupado)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Reference model state: bytes expected on listo, in order.
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_listo = 0;
    int         n_err = 0;
    int         listo_cyc = 0;
    bit         prev_listo = 1'b0;
    bit         prev_err = 1'b0;
    bit         ocupado_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: strobe shape, framing and byte scoreboard.
    always @(negedge clk) begin
        if (listo || error_trama)
            check("strobe_exclusive", {31'd0, listo && error_trama}, 32'd0);
        if (listo) begin
            n_listo++;
            listo_cyc = cyc;
            check("listo_width", {31'd0, prev_listo}, 32'd0);
            check("ocupado_fall", {31'd0, ocupado}, 32'd0);
            if (exp_q.size() == 0) begin
                check("listo_unexpected", 32'd1, 32'd0);
            end else begin
                last_good = exp_q.pop_front();
                check("datos", {24'd0, datos}, {24'd0, last_good});
            end
        end
        if (error_trama) begin
            n_err++;
            check("err_width", {31'd0, prev_err}, 32'd0);
            check("datos_hold_on_err", {24'd0, datos}, {24'd0, last_good});
        end
        if (ocupado) ocupado_seen = 1'b1;
        prev_listo = listo;
        prev_err   = error_trama;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    // Serial transmitter model; a good frame is queued as soon as it starts.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) exp_q.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    initial begin
        int base_l, base_e, start_cyc, lat, exp_err;
        logic [7:0] lb [3];

        // 1. Reset and idle line.
        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        check("rst_datos", {24'd0, datos}, 32'h00);
        check("rst_listo", {31'd0, listo}, 32'd0);
        check("rst_err", {31'd0, error_trama}, 32'd0);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        rst = 1'b0;
        ocupado_seen = 1'b0;
        tick(200);
        check("idle_listo", n_listo, 0);
        check("idle_err", n_err, 0);
        check("idle_ocupado", {31'd0, ocupado_seen}, 32'd0);
        check("idle_datos", {24'd0, datos}, 32'h00);

        // 2. Single frame and its latency.
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        tick(20);
        lat = listo_cyc - start_cyc;
        check("single_count", n_listo, 1);
        check("latency_154pm1", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        check("single_datos_held", {24'd0, datos}, 32'hA5);

        // 3. Back-to-back frames, as from a directly connected transmitter.
        base_l = n_listo;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;
        for (int i = 0; i < 3; i++) send_frame(lb[i], 1'b1);
        tick(20);
        check("b2b_count", n_listo - base_l, 3);
        check("b2b_err", n_err, 0);
        check("b2b_queue", exp_q.size(), 0);

        // 4. Short glitch.
        base_l = n_listo;
        ocupado_seen = 1'b0;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_ocupado_seen", {31'd0, ocupado_seen}, 32'd1);
        check("glitch_no_listo", n_listo - base_l, 0);
        check("glitch_no_err", n_err, 0);
        check("glitch_datos", {24'd0, datos}, 32'h55);
        check("glitch_idle", {31'd0, ocupado}, 32'd0);

        // 5. Framing error, line held low, then recovery.
        base_l = n_listo;
        send_frame(8'h3C, 1'b0);
        tick(100);
        check("ferr_count", n_err, 1);
        check("ferr_no_listo", n_listo - base_l, 0);
        check("ferr_datos", {24'd0, datos}, 32'h55);
        check("ferr_break_busy", {31'd0, ocupado}, 32'd1);
        rx = 1'b1;
        tick(20);
        check("ferr_released", {31'd0, ocupado}, 32'd0);
        send_frame(8'h81, 1'b1);
        tick(20);
        check("ferr_recover_count", n_listo - base_l, 1);
        check("ferr_recover_datos", {24'd0, datos}, 32'h81);

        // 6. Reset late in bit 3 of 8'hF0.
        base_l = n_listo;
        base_e = n_err;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        rx = 1'b0;
        tick(13);
        rst = 1'b1;
        tick(1);
        check("mid_rst_datos", {24'd0, datos}, 32'h00);
        check("mid_rst_ocupado", {31'd0, ocupado}, 32'd0);
        check("mid_rst_listo", {31'd0, listo}, 32'd0);
        rst = 1'b0;
        last_good = 8'h00;
        exp_q.delete();
        tick(2);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        tick(40);
        check("mid_rst_no_listo", n_listo - base_l, 0);
        check("mid_rst_no_err", n_err - base_e, 0);
        send_frame(8'h12, 1'b1);
        tick(20);
        check("mid_rst_next_count", n_listo - base_l, 1);
        check("mid_rst_next_datos", {24'd0, datos}, 32'h12);

        // Random frames with random gaps and occasional bad stop bits.
        base_l  = n_listo;
        exp_err = n_err;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            logic       ok;
            int         gap;
            b   = 8'($urandom);
            ok  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 30);
            if (!ok) begin
                exp_err++;
                if (gap < 4) gap = 4;
            end
            send_frame(b, ok);
            rx = 1'b1;
            if (gap > 0) tick(gap);
        end
        tick(40);
        check("rand_err_count", n_err, exp_err);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_idle", {31'd0, ocupado}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/recibir_datos.md
Name: recibir_datos

Overview:
- UART receiver: the downstream stage of the `EnviarDatos` serial transmitter.
- Deserialises the 8N1 stream on `rx` (idle high, 1 start bit, 8 data bits LSB first, 1 stop bit) into a parallel byte.
- Presents the byte with a one-cycle `listo` strobe.
- Used on the board link and in loopback benches where `EnviarDatos.tx` drives `rx` directly.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud); must be >= 4. Benches use 16.
- SYNC_STAGES, 2, flip-flop stages of the `rx` synchroniser; allowed values 2..3.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- datos  output  8  last correctly framed byte; held until the next good frame
- listo  output  1  one-cycle pulse: `datos` has just been updated
- error_trama  output  1  one-cycle pulse: stop bit sampled low (framing error)
- ocupado  output  1  high while state != IDLE

Behaviour:
- Reset, sampled on a rising `clk` edge while `rst`=1:
  - `datos`=8'h00, `listo`=0, `error_trama`=0, `ocupado`=0.
  - State goes to IDLE; bit counter and baud counter are cleared.
  - Synchroniser flops are set to 1 (line idle).
  - A reset mid-frame aborts the frame with no strobe.
- Synchroniser: `rx` passes through SYNC_STAGES flops; `rxs` is the last stage. All decisions use `rxs` only.
- Baud counter `cnt`: width $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- States:
  - IDLE: if `rxs`==0, go to START with `cnt`=0.
  - START: count to (CLKS_PER_BIT/2)-1, which is mid start bit. If `rxs`==0 there, go to DATA with `cnt`=0 and `bit_idx`=0. If `rxs`==1, treat it as a glitch and return to IDLE with no strobe.
  - DATA: on every `cnt`==CLKS_PER_BIT-1 (mid-bit):
    - shift `rxs` into `shreg[bit_idx]`, so bit 0 is received first;
    - clear `cnt`;
    - increment `bit_idx` (3-bit);
    - after bit 7 is taken, go to STOP.
  - STOP: at `cnt`==CLKS_PER_BIT-1, sample `rxs`.
    - If 1: `datos`<=`shreg`, `listo`<=1 for exactly one cycle, go to IDLE.
    - If 0: `error_trama`<=1 for one cycle, `datos` unchanged, go to BREAK.
  - BREAK: wait until `rxs`==1, then go to IDLE. A line held low never re-triggers a frame.
- `listo` and `error_trama` are never high in the same cycle. Neither is ever high for two consecutive cycles.
- Latency: `listo` rises SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (±1) after the start-bit falling edge on `rx`.
- Back-to-back frames: the state is back in IDLE mid stop bit, so a start edge immediately after the stop bit is caught with no lost frame.
- Counter comparisons are exact equality; no wrap occurs because `cnt` is cleared at every terminal count.
- No FIFO: a new frame overwrites `datos`. The consumer must take `datos` on `listo`.

Test Plan:
1. Reset, CLKS_PER_BIT=16, `rx`=1 for 200 cycles -> `datos`=8'h00, `listo`/`error_trama`/`ocupado` stay 0 throughout.
2. Single frame 8'hA5 driven at 16 clk/bit (start 0; bits 1,0,1,0,0,1,0,1; stop 1):
   - `listo` pulses once, 1 cycle wide, 154±1 cycles after the start edge (SYNC_STAGES=2);
   - `datos`=8'hA5 from that cycle onward;
   - `ocupado` falls in the same cycle.
3. Loopback: instantiate `EnviarDatos` with the same bit period, tx->rx, send 8'h00, 8'hFF, 8'h55 back-to-back -> three `listo` pulses with `datos` 8'h00, 8'hFF, 8'h55 in order, `error_trama` never asserted.
4. Glitch: `rx` low for 4 cycles then high -> `ocupado` pulses briefly, then IDLE; no `listo`, no `error_trama`; `datos` keeps its previous value.
5. Framing error: frame 8'h3C with stop bit driven 0, line held low 100 cycles, then high, then a good frame 8'h81:
   - `error_trama` pulses once and `datos` is unchanged;
   - no new frame starts while the line is low;
   - the good frame then yields `listo` with `datos`=8'h81.
6. Reset mid-frame: assert `rst` 1 cycle during bit 3 of frame 8'hF0 -> outputs return to reset values, no strobe for the aborted frame; a subsequent clean frame 8'h12 is received correctly.
